// File: rtl/alu_mul_sequencer_if.sv
// Operand/result bundle between the ALU operand bus, the multiplier and the result mux.
// Handshake: a transfer happens on a rising edge where valid && ready; the producer holds
// its payload and valid until that edge, and the consumer never depends on valid to raise ready.
interface alu_mul_sequencer_if #(parameter int WIDTH = 4);
  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 abort;
  logic                 busy;
  logic [2*WIDTH-1:0]   p;
  logic                 p_valid;
  logic                 p_ready;
  logic [1:0]           dbg_state;

  modport slave (
    input  start_valid, a, b, abort, p_ready,
    output start_ready, busy, p, p_valid, dbg_state
  );

  modport master (
    output start_valid, a, b, abort, p_ready,
    input  start_ready, busy, p, p_valid, dbg_state
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-and-add multiplier: one ADD and one SHIFT step per multiplier bit,
// using a carry-keeping add and a 1-bit right shift of {C,ACC,Q}.
module alu_mul_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_mul_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 c_q, c_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      q_q     <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      q_q     <= q_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    c_d     = c_q;
    q_d     = q_q;
    count_d = count_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = '0;
          c_d     = 1'b0;
          count_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (q_q[0]) begin
            {c_d, acc_d} = {1'b0, acc_q} + {1'b0, m_q};
          end else begin
            {c_d, acc_d} = {1'b0, acc_q};
          end
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          // The add's carry drops into the ACC MSB; the multiplier bit just used falls off Q.
          {c_d, acc_d, q_d} = {1'b0, c_q, acc_q, q_q[WIDTH-1:1]};
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            p_d     = {acc_d, q_d};
            state_d = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_DONE: begin
        if (bus.p_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q == S_ADD) || (state_q == S_SHIFT);
  assign bus.p_valid     = (state_q == S_DONE);
  assign bus.p           = p_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and randomized checks of alu_mul_sequencer against a plain a*b product model.
module tb_alu_mul_sequencer;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // driver: present a request at a negedge; returns one negedge after the accept edge
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    bus.a           = av;
    bus.b           = bv;
    bus.start_valid = 1'b1;
    check("start_ready_at_req", 32'(bus.start_ready), 1);
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.a           = WIDTH'($urandom_range(0, 15));
    bus.b           = WIDTH'($urandom_range(0, 15));
  endtask

  task automatic wait_result(output int wait_c, output int busy_c);
    wait_c = 0;
    busy_c = 0;
    while (!bus.p_valid && wait_c < 40) begin
      if (bus.busy) busy_c++;
      wait_c++;
      @(negedge clk);
    end
  endtask

  task automatic mul_check(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int wc;
    int bc;
    start_op(av, bv);
    wait_result(wc, bc);
    check({tag, "_latency"}, 32'(wc), 8);
    check({tag, "_busy_cycles"}, 32'(bc), 8);
    check({tag, "_p_valid"}, 32'(bus.p_valid), 1);
    check({tag, "_p"}, 32'(bus.p), int'(av) * int'(bv));
    @(negedge clk);
  endtask

  initial begin
    int wc;
    int bc;
    int seen;
    int hold;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int idx;
    int n_res;
    int last_acc;
    int cyc;
    int gap_bad;
    bit adv;

    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.abort       = 1'b0;
    bus.p_ready     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_p_valid", 32'(bus.p_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_start_ready", 32'(bus.start_ready), 1);
    check("rst_p", 32'(bus.p), 0);
    check("rst_state_idle", 32'(bus.dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // full-scale operands
    mul_check("max", 4'd15, 4'd15);
    check("max_p_const", 32'(bus.p), 32'h0000_00E1);

    // reset landing in SHIFT discards the multiply
    start_op(4'd9, 4'd9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_p", 32'(bus.p), 0);
    check("midrst_p_valid", 32'(bus.p_valid), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_start_ready", 32'(bus.start_ready), 1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.p_valid || bus.busy) seen++;
    end
    check("midrst_no_result", 32'(seen), 0);

    // zero operands and unity multiplicand
    mul_check("zero_a", 4'd0, 4'd9);
    mul_check("zero_b", 4'd7, 4'd0);
    mul_check("one_a", 4'd1, 4'd15);

    // consumer stall with a waiting request
    bus.p_ready = 1'b0;
    start_op(4'd12, 4'd11);
    wait_result(wc, bc);
    check("stall_latency", 32'(wc), 8);
    bus.a           = 4'd2;
    bus.b           = 4'd3;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_p", 32'(bus.p), 32'h84);
      check("stall_p_valid", 32'(bus.p_valid), 1);
      check("stall_start_ready", 32'(bus.start_ready), 0);
      @(negedge clk);
    end
    bus.p_ready = 1'b1;
    @(negedge clk);
    check("release_idle", 32'(bus.start_ready), 1);
    check("release_p_valid", 32'(bus.p_valid), 0);
    check("release_p_held", 32'(bus.p), 32'h84);
    @(negedge clk);
    bus.start_valid = 1'b0;
    check("release_accept_busy", 32'(bus.busy), 1);
    wait_result(wc, bc);
    check("release_latency", 32'(wc), 8);
    check("release_p", 32'(bus.p), 6);
    @(negedge clk);

    // abort on the third busy cycle beats a simultaneous request
    start_op(4'd6, 4'd5);
    @(negedge clk);
    @(negedge clk);
    bus.abort       = 1'b1;
    bus.a           = 4'd3;
    bus.b           = 4'd4;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_idle", 32'(bus.start_ready), 1);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_p_valid", 32'(bus.p_valid), 0);
    check("abort_p_unchanged", 32'(bus.p), 6);
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.a           = 4'd15;
    bus.b           = 4'd15;
    check("post_abort_busy", 32'(bus.busy), 1);
    wait_result(wc, bc);
    check("post_abort_latency", 32'(wc), 8);
    check("post_abort_p", 32'(bus.p), 32'h0C);
    @(negedge clk);

    // randomized operands with random consumer stalls
    for (int n = 0; n < 30; n++) begin
      ra          = WIDTH'($urandom_range(0, 15));
      rb          = WIDTH'($urandom_range(0, 15));
      hold        = $urandom_range(0, 3);
      bus.p_ready = (hold == 0);
      start_op(ra, rb);
      wait_result(wc, bc);
      check("rnd_latency", 32'(wc), 8);
      check("rnd_p", 32'(bus.p), int'(ra) * int'(rb));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("rnd_hold_p", 32'(bus.p), int'(ra) * int'(rb));
        check("rnd_hold_valid", 32'(bus.p_valid), 1);
      end
      bus.p_ready = 1'b1;
      @(negedge clk);
    end

    // every operand pair back-to-back through an expected queue
    idx             = 0;
    n_res           = 0;
    last_acc        = -1;
    cyc             = 0;
    gap_bad         = 0;
    adv             = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.start_valid = 1'b1;
    while (n_res < 256 && cyc < 4000) begin
      if (bus.p_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected_result", 1, 0);
        else check("b2b_p", 32'(bus.p), 32'(exp_q.pop_front()));
        n_res++;
      end
      if (bus.start_valid && bus.start_ready) begin
        exp_q.push_back((2*WIDTH)'(int'(bus.a) * int'(bus.b)));
        if (last_acc >= 0 && cyc - last_acc != 10) gap_bad++;
        last_acc = cyc;
        idx++;
        adv = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (adv) begin
        adv = 1'b0;
        if (idx == 256) begin
          bus.start_valid = 1'b0;
        end else begin
          bus.a = WIDTH'(idx % 16);
          bus.b = WIDTH'(idx / 16);
        end
      end
    end
    check("b2b_accepts", 32'(idx), 256);
    check("b2b_results", 32'(n_res), 256);
    check("b2b_queue_empty", 32'(exp_q.size()), 0);
    check("b2b_accept_spacing", 32'(gap_bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
